// File: rtl/wb_host_arb_pkg.sv
// Shared definitions for the three-master Wishbone host arbiter:
// master count, grant index width, FSM state encoding and target-id decode.
package wb_host_arb_pkg;

  localparam int NM = 3;
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    REL  = 2'd2
  } arb_state_t;

  // The target slave is selected by the top nibble of the address.
  function automatic logic [3:0] tid_decode(input logic [31:0] adr);
    return 4'(adr >> 28);
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last
// granted master and wraps, so every requester is served within NM grants.
module wb_rr_pick
  import wb_host_arb_pkg::*;
(
  input  logic [NM-1:0] req,
  input  logic [GW-1:0] last_gnt,
  output logic [GW-1:0] gnt,
  output logic          valid
);

  // Scan from the farthest candidate to the nearest so the nearest requester
  // after last_gnt is the one left in gnt.
  always_comb begin
    int          idx;
    logic [GW-1:0] idx_s;
    idx   = 0;
    idx_s = '0;
    gnt   = '0;
    valid = |req;
    for (int k = NM; k >= 1; k--) begin
      idx   = (int'(last_gnt) + k) % NM;
      idx_s = GW'(idx);
      if (req[idx_s]) begin
        gnt = idx_s;
      end
    end
  end

endmodule

// File: rtl/wb_host_arb.sv
// Three-master Wishbone arbiter and address decoder feeding the stagging
// stage. One master owns the bus per transaction; the slave response is
// routed back combinationally, and a timeout stops a dead slave from
// holding the interconnect forever.
module wb_host_arb
  import wb_host_arb_pkg::*;
#(
  parameter int TO_CYC = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n,

  input  logic [NM-1:0][31:0]   m_wbd_dat_i,
  input  logic [NM-1:0][31:0]   m_wbd_adr_i,
  input  logic [NM-1:0][3:0]    m_wbd_sel_i,
  input  logic [NM-1:0]         m_wbd_we_i,
  input  logic [NM-1:0]         m_wbd_cyc_i,
  input  logic [NM-1:0]         m_wbd_stb_i,
  output logic [NM-1:0][31:0]   m_wbd_dat_o,
  output logic [NM-1:0]         m_wbd_ack_o,
  output logic [NM-1:0]         m_wbd_err_o,

  output logic [31:0]           s_wbd_dat_o,
  output logic [31:0]           s_wbd_adr_o,
  output logic [3:0]            s_wbd_sel_o,
  output logic                  s_wbd_we_o,
  output logic                  s_wbd_cyc_o,
  output logic                  s_wbd_stb_o,
  output logic [3:0]            s_wbd_tid_o,
  input  logic [31:0]           s_wbd_dat_i,
  input  logic                  s_wbd_ack_i,
  input  logic                  s_wbd_err_i
);

  localparam int CW = $clog2(TO_CYC + 1);

  arb_state_t    state;
  logic [GW-1:0] gnt;
  logic [GW-1:0] last_gnt;
  logic [CW-1:0] cnt;

  logic [NM-1:0] req;
  logic [GW-1:0] pick_gnt;
  logic          pick_valid;
  logic          busy;
  logic          g_cyc;
  logic          timeout;
  logic          finish;

  assign req     = m_wbd_cyc_i & m_wbd_stb_i;
  assign busy    = (state == BUSY);
  assign g_cyc   = m_wbd_cyc_i[gnt];
  assign timeout = busy && (cnt == CW'(TO_CYC));
  assign finish  = !g_cyc || s_wbd_ack_i || s_wbd_err_i || timeout;

  wb_rr_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (pick_gnt),
    .valid    (pick_valid)
  );

  // Arbitration FSM: grant in IDLE, hold the bus in BUSY until the slave
  // answers, times out or the master aborts, then insert one REL gap.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= GW'(NM - 1);
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_gnt;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            state    <= REL;
            last_gnt <= gnt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Forward the granted master's request only while the bus is owned.
  always_comb begin
    s_wbd_dat_o = '0;
    s_wbd_adr_o = '0;
    s_wbd_sel_o = '0;
    s_wbd_we_o  = 1'b0;
    s_wbd_cyc_o = 1'b0;
    s_wbd_stb_o = 1'b0;
    s_wbd_tid_o = '0;
    if (busy) begin
      s_wbd_dat_o = m_wbd_dat_i[gnt];
      s_wbd_adr_o = m_wbd_adr_i[gnt];
      s_wbd_sel_o = m_wbd_sel_i[gnt];
      s_wbd_we_o  = m_wbd_we_i[gnt];
      s_wbd_cyc_o = m_wbd_cyc_i[gnt];
      s_wbd_stb_o = m_wbd_stb_i[gnt];
      s_wbd_tid_o = tid_decode(m_wbd_adr_i[gnt]);
    end
  end

  // Route the slave response to the granted master; an aborted cycle gets
  // nothing, and a coincident ack suppresses the timeout error.
  always_comb begin
    m_wbd_dat_o = '0;
    m_wbd_ack_o = '0;
    m_wbd_err_o = '0;
    if (busy && g_cyc) begin
      m_wbd_ack_o[gnt] = s_wbd_ack_i;
      m_wbd_err_o[gnt] = s_wbd_err_i | (timeout & ~s_wbd_ack_i);
      if (s_wbd_ack_i) begin
        m_wbd_dat_o[gnt] = s_wbd_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_host_arb.sv
// Directed self-checking bench for wb_host_arb with a short timeout.
module tb_wb_host_arb;

  localparam int NM = 3;

  logic                clk;
  logic                rst_n;
  logic [NM-1:0][31:0] m_dat_i;
  logic [NM-1:0][31:0] m_adr_i;
  logic [NM-1:0][3:0]  m_sel_i;
  logic [NM-1:0]       m_we_i;
  logic [NM-1:0]       m_cyc_i;
  logic [NM-1:0]       m_stb_i;
  logic [NM-1:0][31:0] m_dat_o;
  logic [NM-1:0]       m_ack_o;
  logic [NM-1:0]       m_err_o;
  logic [31:0]         s_dat_o;
  logic [31:0]         s_adr_o;
  logic [3:0]          s_sel_o;
  logic                s_we_o;
  logic                s_cyc_o;
  logic                s_stb_o;
  logic [3:0]          s_tid_o;
  logic [31:0]         s_dat_i;
  logic                s_ack_i;
  logic                s_err_i;

  int tests  = 0;
  int failed = 0;

  wb_host_arb #(.TO_CYC(8)) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .m_wbd_dat_i (m_dat_i),
    .m_wbd_adr_i (m_adr_i),
    .m_wbd_sel_i (m_sel_i),
    .m_wbd_we_i  (m_we_i),
    .m_wbd_cyc_i (m_cyc_i),
    .m_wbd_stb_i (m_stb_i),
    .m_wbd_dat_o (m_dat_o),
    .m_wbd_ack_o (m_ack_o),
    .m_wbd_err_o (m_err_o),
    .s_wbd_dat_o (s_dat_o),
    .s_wbd_adr_o (s_adr_o),
    .s_wbd_sel_o (s_sel_o),
    .s_wbd_we_o  (s_we_o),
    .s_wbd_cyc_o (s_cyc_o),
    .s_wbd_stb_o (s_stb_o),
    .s_wbd_tid_o (s_tid_o),
    .s_wbd_dat_i (s_dat_i),
    .s_wbd_ack_i (s_ack_i),
    .s_wbd_err_i (s_err_i)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic cyc, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i[idx] = cyc;
    m_stb_i[idx] = cyc;
    m_we_i[idx]  = we;
    m_adr_i[idx] = adr;
    m_dat_i[idx] = dat;
    m_sel_i[idx] = cyc ? 4'hF : 4'h0;
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    m_dat_i = '0;
    m_adr_i = '0;
    m_sel_i = '0;
    m_we_i  = '0;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;

    // Reset values
    waitCycle();
    waitCycle();
    checkOutput("rst_stb", s_stb_o, 0);
    checkOutput("rst_cyc", s_cyc_o, 0);
    checkOutput("rst_ack", m_ack_o, 0);
    checkOutput("rst_err", m_err_o, 0);
    checkOutput("rst_mdat", m_dat_o, 0);
    rst_n = 1'b1;
    waitCycle();

    // Single write from master 1, slave acks two cycles after strobe
    applyStimulus(1, 1'b1, 1'b1, 32'h3000_0010, 32'h1234_5678);
    #1;
    checkOutput("t1_idle_stb", s_stb_o, 0);
    waitCycle();
    checkOutput("t1_stb", s_stb_o, 1);
    checkOutput("t1_tid", s_tid_o, 4'h3);
    checkOutput("t1_adr", s_adr_o, 32'h3000_0010);
    checkOutput("t1_dat", s_dat_o, 32'h1234_5678);
    checkOutput("t1_we", s_we_o, 1);
    checkOutput("t1_sel", s_sel_o, 4'hF);
    waitCycle();
    checkOutput("t1_no_early_ack", m_ack_o, 0);
    waitCycle();
    s_ack_i = 1'b1;
    #1;
    checkOutput("t1_ack", m_ack_o, 3'b010);
    checkOutput("t1_err", m_err_o, 0);
    waitCycle();
    s_ack_i = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t1_rel_stb", s_stb_o, 0);
    checkOutput("t1_rel_cyc", s_cyc_o, 0);
    waitCycle();
    checkOutput("t1_idle_after", s_stb_o, 0);

    // All three masters request continuously right after reset
    rst_n = 1'b0;
    waitCycle();
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h2000_0004, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h5000_0008, 32'h0);
    begin
      logic [3:0] exp_tid [4];
      logic [2:0] exp_ack [4];
      exp_tid = '{4'h1, 4'h2, 4'h5, 4'h1};
      exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
      for (int i = 0; i < 4; i++) begin
        waitCycle();
        checkOutput($sformatf("rr_tid_%0d", i), s_tid_o, exp_tid[i]);
        s_ack_i = 1'b1;
        #1;
        checkOutput($sformatf("rr_ack_%0d", i), m_ack_o, exp_ack[i]);
        waitCycle();
        s_ack_i = 1'b0;
        if (i == 3) begin
          for (int m = 0; m < NM; m++) applyStimulus(m, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        #1;
        checkOutput($sformatf("rr_rel_stb_%0d", i), s_stb_o, 0);
        checkOutput($sformatf("rr_rel_ack_%0d", i), m_ack_o, 0);
        waitCycle();
        checkOutput($sformatf("rr_idle_stb_%0d", i), s_stb_o, 0);
      end
    end

    // Read from master 2 returns data only to master 2 and only on ack
    applyStimulus(2, 1'b1, 1'b0, 32'h7000_0000, 32'h0);
    waitCycle();
    checkOutput("rd_we", s_we_o, 0);
    s_dat_i = 32'hDEAD_BEEF;
    #1;
    checkOutput("rd_dat_noack", m_dat_o, 0);
    waitCycle();
    s_ack_i = 1'b1;
    #1;
    checkOutput("rd_ack", m_ack_o, 3'b100);
    checkOutput("rd_dat", m_dat_o, {32'hDEAD_BEEF, 64'h0});
    waitCycle();
    s_ack_i = 1'b0;
    s_dat_i = '0;
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("rd_rel_dat", m_dat_o, 0);
    waitCycle();

    // Slave never answers master 0: one timeout error after 8 silent cycles
    applyStimulus(0, 1'b1, 1'b1, 32'h4000_0000, 32'h55);
    waitCycle();
    checkOutput("to_tid", s_tid_o, 4'h4);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("to_quiet_%0d", k), m_err_o, 0);
      waitCycle();
    end
    checkOutput("to_err", m_err_o, 3'b001);
    checkOutput("to_noack", m_ack_o, 0);
    waitCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack_i = 1'b1;
    #1;
    checkOutput("to_late_ack_rel", m_ack_o, 0);
    checkOutput("to_err_once", m_err_o, 0);
    waitCycle();
    checkOutput("to_late_ack_idle", m_ack_o, 0);
    s_ack_i = 1'b0;
    waitCycle();

    // Master 0 aborts mid-transaction while master 1 waits
    applyStimulus(0, 1'b1, 1'b0, 32'h1100_0000, 32'h0);
    waitCycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h6000_0000, 32'h0);
    #1;
    checkOutput("ab_owner_adr", s_adr_o, 32'h1100_0000);
    waitCycle();
    checkOutput("ab_pending_noack", m_ack_o, 0);
    checkOutput("ab_cyc_before", s_cyc_o, 1);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("ab_cyc_low", s_cyc_o, 0);
    checkOutput("ab_noack", m_ack_o, 0);
    checkOutput("ab_noerr", m_err_o, 0);
    waitCycle();
    checkOutput("ab_rel_stb", s_stb_o, 0);
    waitCycle();
    checkOutput("ab_idle_stb", s_stb_o, 0);
    waitCycle();
    checkOutput("ab_m1_tid", s_tid_o, 4'h6);
    checkOutput("ab_m1_adr", s_adr_o, 32'h6000_0000);
    s_ack_i = 1'b1;
    #1;
    checkOutput("ab_m1_ack", m_ack_o, 3'b010);
    waitCycle();
    s_ack_i = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();

    // Reset during BUSY clears everything at once; master 0 wins afterwards
    applyStimulus(2, 1'b1, 1'b0, 32'h9000_0000, 32'h0);
    waitCycle();
    checkOutput("rb_m2_tid", s_tid_o, 4'h9);
    rst_n   = 1'b0;
    s_ack_i = 1'b1;
    #1;
    checkOutput("rb_stb", s_stb_o, 0);
    checkOutput("rb_cyc", s_cyc_o, 0);
    checkOutput("rb_ack", m_ack_o, 0);
    checkOutput("rb_err", m_err_o, 0);
    checkOutput("rb_adr", s_adr_o, 0);
    applyStimulus(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    waitCycle();
    s_ack_i = 1'b0;
    rst_n   = 1'b1;
    #1;
    checkOutput("rb_idle_stb", s_stb_o, 0);
    waitCycle();
    checkOutput("rb_first_tid", s_tid_o, 4'h1);
    checkOutput("rb_first_adr", s_adr_o, 32'h1000_0000);
    for (int m = 0; m < NM; m++) applyStimulus(m, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
